pgr_uart_cmd_parser_32bit: RTL

- Upstream command stage of the UART-to-APB bridge.
- Pops bytes from the UART RX FIFO, parses a fixed frame (command, address, optional write data) and issues one 32-bit APB command to the APB master interface. That interface takes strb/addr/data/we/cmd_en and returns cmd_done.
- Guarantees only one command is in flight at a time.
- Drops malformed or stalled frames and pulses an error flag.

---
 rtl/pgr_uart2apb_pkg.sv | 22 ++
 rtl/pgr_uart_cmd_parser_32bit_if.sv | 14 +
 rtl/pgr_uart_cmd_timer.sv | 28 ++
 rtl/pgr_uart_cmd_parser_32bit.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/pgr_uart2apb_pkg.sv
// Shared definitions for the UART-to-APB bridge: parser states, frame sync
// pattern and frame lengths.
package pgr_uart2apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_DATA,
        ST_ISSUE,
        ST_WAIT_DONE
    } parser_state_t;

    localparam logic [2:0] SYNC_PATTERN = 3'b101;
    localparam int READ_LEN  = 3;
    localparam int WRITE_LEN = 7;

    function automatic logic is_header(input logic [7:0] b);
        return b[6:4] == SYNC_PATTERN;
    endfunction

endpackage

// File: rtl/pgr_uart_cmd_parser_32bit_if.sv
// Command bus between the frame parser and the APB master interface.
interface pgr_uart_cmd_parser_32bit_if;

    logic [3:0]  strb;
    logic [15:0] addr;
    logic [31:0] data;
    logic        we;
    logic        cmd_en;
    logic        cmd_done;

    modport master (output strb, addr, data, we, cmd_en, input cmd_done);
    modport slave  (input strb, addr, data, we, cmd_en, output cmd_done);

endinterface

// File: rtl/pgr_uart_cmd_timer.sv
// Down-counting timeout: reloads to LIMIT on load, counts while enabled and
// flags expire on the LIMIT-th consecutive enabled cycle without a load.
module pgr_uart_cmd_timer #(
    parameter int WIDTH = 16,
    parameter int LIMIT = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= WIDTH'(LIMIT);
        end else if (load) begin
            cnt <= WIDTH'(LIMIT);
        end else if (en && cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expire = en & ~load & (cnt == WIDTH'(1));

endmodule

// File: rtl/pgr_uart_cmd_parser_32bit.sv
// Parses CMD/ADDR/DATA frames from the UART RX FIFO and issues one APB
// command at a time; malformed or stalled frames are dropped with frame_err.
//
// state     | meaning
// IDLE      | waiting for a header byte with the sync pattern
// ADDR_H    | collecting address high byte
// ADDR_L    | collecting address low byte
// DATA      | collecting write data bytes D0..D3
// ISSUE     | cmd_en high for one cycle
// WAIT_DONE | waiting for cmd_done or the done timeout
module pgr_uart_cmd_parser_32bit
    import pgr_uart2apb_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 'd4096,
    parameter int DONE_TIMEOUT = 'd1023
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               rx_fifo_empty,
    output logic                               rx_fifo_rd_en,
    input  logic [7:0]                         rx_fifo_data,
    pgr_uart_cmd_parser_32bit_if.master        cmd,
    output logic                               busy,
    output logic                               frame_err
);

    localparam logic [1:0] LAST_DATA_IDX = 2'(WRITE_LEN - READ_LEN - 1);

    parser_state_t state;
    logic          rd_pending;
    logic [1:0]    data_idx;
    logic          hdr_we;
    logic [3:0]    hdr_strb;
    logic [7:0]    addr_h;
    logic [7:0]    addr_l;
    logic [23:0]   data_sh;
    logic          receiving;
    logic          in_frame;
    logic          byte_expire;
    logic          done_expire;

    assign in_frame  = (state == ST_ADDR_H) || (state == ST_ADDR_L) || (state == ST_DATA);
    assign receiving = in_frame || (state == ST_IDLE);
    assign rx_fifo_rd_en = ~rst & receiving & ~rx_fifo_empty & ~rd_pending;

    // A capture reloads the byte timer, so a same-cycle timeout is suppressed.
    pgr_uart_cmd_timer #(.WIDTH(16), .LIMIT(BYTE_TIMEOUT)) u_byte_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (~in_frame | rd_pending),
        .en     (in_frame),
        .expire (byte_expire)
    );

    pgr_uart_cmd_timer #(.WIDTH(11), .LIMIT(DONE_TIMEOUT)) u_done_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (state != ST_WAIT_DONE),
        .en     (state == ST_WAIT_DONE),
        .expire (done_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            rd_pending <= 1'b0;
            data_idx   <= '0;
            hdr_we     <= 1'b0;
            hdr_strb   <= '0;
            addr_h     <= '0;
            addr_l     <= '0;
            data_sh    <= '0;
            cmd.strb   <= '0;
            cmd.addr   <= '0;
            cmd.data   <= '0;
            cmd.we     <= 1'b0;
            cmd.cmd_en <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rd_pending <= rx_fifo_rd_en;
            cmd.cmd_en <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_pending) begin
                        if (is_header(rx_fifo_data)) begin
                            hdr_we   <= rx_fifo_data[7];
                            hdr_strb <= rx_fifo_data[3:0];
                            state    <= ST_ADDR_H;
                            busy     <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                ST_ADDR_H: begin
                    if (rd_pending) begin
                        addr_h <= rx_fifo_data;
                        state  <= ST_ADDR_L;
                    end else if (byte_expire) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                ST_ADDR_L: begin
                    if (rd_pending) begin
                        addr_l   <= rx_fifo_data;
                        data_idx <= '0;
                        if (hdr_we) begin
                            state <= ST_DATA;
                        end else begin
                            cmd.strb   <= hdr_strb;
                            cmd.addr   <= {addr_h, rx_fifo_data};
                            cmd.data   <= '0;
                            cmd.we     <= 1'b0;
                            cmd.cmd_en <= 1'b1;
                            state      <= ST_ISSUE;
                        end
                    end else if (byte_expire) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rd_pending) begin
                        // LSB first: shift each new byte in from the top.
                        if (data_idx == LAST_DATA_IDX) begin
                            cmd.strb   <= hdr_strb;
                            cmd.addr   <= {addr_h, addr_l};
                            cmd.data   <= {rx_fifo_data, data_sh};
                            cmd.we     <= 1'b1;
                            cmd.cmd_en <= 1'b1;
                            state      <= ST_ISSUE;
                        end else begin
                            data_sh  <= {rx_fifo_data, data_sh[23:8]};
                            data_idx <= data_idx + 2'd1;
                        end
                    end else if (byte_expire) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (cmd.cmd_done) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (done_expire) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        frame_err <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
